ddr_port_arbiter: RTL and testbench

// Shares the single MIG user port between the four DDR movers: bias fetch (0), weight fetch (1),

---
 rtl/ddr_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_ddr_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_port_arbiter.sv
// Round-robin owner of the single MIG user port for the four DDR movers.
// One owner per transfer; issues its read/write commands and routes data.
module ddr_port_arbiter #(
  parameter int DDR_ADDR_LEN = 32,
  parameter int SINGLE_LEN   = 24,
  parameter int DATA_W       = 512,
  parameter int ADDR_STEP    = 8,
  parameter int WR_PORT      = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [3:0]                    i_req,
  input  logic [3:0][DDR_ADDR_LEN-1:0]  i_req_addr,
  input  logic [3:0][SINGLE_LEN-1:0]    i_req_len,
  output logic [3:0]                    o_gnt,
  output logic [3:0]                    o_done,
  output logic                          o_busy,
  output logic                          o_app_en,
  output logic [2:0]                    o_app_cmd,
  output logic [DDR_ADDR_LEN-1:0]       o_app_addr,
  input  logic                          i_app_rdy,
  input  logic [DATA_W-1:0]             i_wr_data,
  input  logic                          i_wr_valid,
  output logic                          o_wr_ready,
  output logic                          o_app_wdf_wren,
  output logic                          o_app_wdf_end,
  output logic [DATA_W-1:0]             o_app_wdf_data,
  input  logic                          i_app_wdf_rdy,
  input  logic [DATA_W-1:0]             i_app_rd_data,
  input  logic                          i_app_rd_data_valid,
  output logic [DATA_W-1:0]             o_rd_data,
  output logic [3:0]                    o_rd_valid,
  output logic                          o_err_stray
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  state_t                  r_state;
  logic [1:0]              r_owner;
  logic [1:0]              r_rr;
  logic [DDR_ADDR_LEN-1:0] r_cur_addr;
  logic [SINGLE_LEN-1:0]   r_len;
  logic [SINGLE_LEN-1:0]   r_cmd_cnt;
  logic [SINGLE_LEN-1:0]   r_rd_cnt;
  logic [SINGLE_LEN-1:0]   r_wd_cnt;
  logic [3:0]              r_gnt;
  logic [3:0]              r_done;
  logic                    r_busy;
  logic                    r_err_stray;

  logic [1:0] w_pick;
  logic [1:0] w_idx;
  logic       w_found;
  logic       w_xfer;
  logic       w_is_wr;
  logic       w_rd_owner;
  logic       w_cmd_fire;
  logic       w_rd_fire;
  logic       w_wd_fire;
  logic       w_xfer_end;
  logic       w_stray;

  // First requester at or above the rr pointer, wrapping mod 4.
  always_comb begin
    w_pick  = r_rr;
    w_idx   = r_rr;
    w_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_rr + 2'(k);
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_xfer     = (r_state == S_XFER);
  assign w_is_wr    = (r_owner == 2'(WR_PORT));
  assign w_rd_owner = w_xfer && !w_is_wr;

  assign o_app_en   = w_xfer && (r_cmd_cnt < r_len);
  assign o_app_cmd  = w_rd_owner ? 3'b001 : 3'b000;
  assign o_app_addr = r_cur_addr;
  assign w_cmd_fire = o_app_en && i_app_rdy;

  assign o_wr_ready     = w_xfer && w_is_wr && i_app_wdf_rdy && (r_wd_cnt < r_len);
  assign w_wd_fire      = i_wr_valid && o_wr_ready;
  assign o_app_wdf_wren = w_wd_fire;
  assign o_app_wdf_end  = w_wd_fire;
  assign o_app_wdf_data = i_wr_data;

  assign w_rd_fire  = w_rd_owner && i_app_rd_data_valid;
  assign w_stray    = i_app_rd_data_valid && !w_rd_owner;
  assign o_rd_data  = i_app_rd_data;
  assign o_rd_valid = w_rd_fire ? (4'b0001 << r_owner) : 4'b0000;

  // Completion needs every command accepted and every data beat moved.
  assign w_xfer_end = (r_cmd_cnt == r_len) &&
                      (w_is_wr ? (r_wd_cnt == r_len) : (r_rd_cnt == r_len));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_owner     <= '0;
      r_rr        <= '0;
      r_cur_addr  <= '0;
      r_len       <= '0;
      r_cmd_cnt   <= '0;
      r_rd_cnt    <= '0;
      r_wd_cnt    <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_busy      <= 1'b0;
      r_err_stray <= 1'b0;
    end else begin
      r_done      <= '0;
      r_err_stray <= r_err_stray | w_stray;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_owner    <= w_pick;
            r_cur_addr <= i_req_addr[w_pick];
            r_len      <= i_req_len[w_pick];
            r_cmd_cnt  <= '0;
            r_rd_cnt   <= '0;
            r_wd_cnt   <= '0;
            r_gnt      <= 4'b0001 << w_pick;
            r_busy     <= 1'b1;
            r_state    <= S_XFER;
          end
        end
        S_XFER: begin
          if (w_cmd_fire) begin
            r_cur_addr <= r_cur_addr + DDR_ADDR_LEN'(ADDR_STEP);
            r_cmd_cnt  <= r_cmd_cnt + SINGLE_LEN'(1);
          end
          if (w_rd_fire) r_rd_cnt <= r_rd_cnt + SINGLE_LEN'(1);
          if (w_wd_fire) r_wd_cnt <= r_wd_cnt + SINGLE_LEN'(1);
          if (w_xfer_end) begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 4'b0001 << r_owner;
            r_rr    <= r_owner + 2'd1;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_gnt       = r_gnt;
  assign o_done      = r_done;
  assign o_busy      = r_busy;
  assign o_err_stray = r_err_stray;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed bench for ddr_port_arbiter: vector table for a basic read, then
// hand sequences for round-robin, write back-pressure, rdy toggling, wrap, reset.
module tb_ddr_port_arbiter;

  logic              clk;
  logic              rst_n;
  logic [3:0]        req;
  logic [3:0][31:0]  req_addr;
  logic [3:0][23:0]  req_len;
  logic [3:0]        o_gnt, o_done, o_rd_valid;
  logic              o_busy, o_app_en, o_wr_ready, o_app_wdf_wren, o_app_wdf_end, o_err_stray;
  logic [2:0]        o_app_cmd;
  logic [31:0]       o_app_addr;
  logic              app_rdy, wr_valid, app_wdf_rdy, man_rdv, auto_rd, rdv_in;
  logic [511:0]      wr_pat, rd_pat, o_app_wdf_data, o_rd_data;
  logic              p1, p2;
  int                n_chk, n_err;

  ddr_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .i_req(req), .i_req_addr(req_addr), .i_req_len(req_len),
    .o_gnt(o_gnt), .o_done(o_done), .o_busy(o_busy), .o_app_en(o_app_en),
    .o_app_cmd(o_app_cmd), .o_app_addr(o_app_addr), .i_app_rdy(app_rdy),
    .i_wr_data(wr_pat), .i_wr_valid(wr_valid), .o_wr_ready(o_wr_ready),
    .o_app_wdf_wren(o_app_wdf_wren), .o_app_wdf_end(o_app_wdf_end),
    .o_app_wdf_data(o_app_wdf_data), .i_app_wdf_rdy(app_wdf_rdy),
    .i_app_rd_data(rd_pat), .i_app_rd_data_valid(rdv_in),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_err_stray(o_err_stray)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MIG read-return model: one beat per accepted read command, one cycle later.
  always @(negedge clk) begin
    p1 <= o_app_en && app_rdy && (o_app_cmd == 3'b001);
    p2 <= p1;
  end
  assign rdv_in = auto_rd ? p2 : man_rdv;

  typedef struct {
    logic [3:0]  req;
    logic        rdy;
    logic        rdv;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic        en;
    logic [31:0] addr;
    logic [3:0]  rdval;
  } vec_t;
  vec_t tv[8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    req = '0; man_rdv = 1'b0; auto_rd = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [63:0] out_bundle();
    return {12'h0, o_gnt, o_done, o_busy, o_app_en, o_app_cmd, o_app_addr,
            o_rd_valid, o_wr_ready, o_err_stray, o_app_wdf_wren};
  endfunction

  initial begin
    logic [3:0]  grants[5];
    logic [3:0]  prev;
    logic [31:0] addrs[8];
    logic [63:0] got, exp;
    int ng, gap, min_gap, na, beats, cmds, g_at, d_at;
    logic any_rdy, early, got_done, bad_cmd, en_seen, done_rst;

    n_chk = 0; n_err = 0;
    rst_n = 1'b0; req = '0; req_addr = '0; req_len = '0;
    app_rdy = 1'b0; wr_valid = 1'b0; app_wdf_rdy = 1'b0; man_rdv = 1'b0; auto_rd = 1'b0;
    wr_pat = {8{64'hA5A5_0000_1234_5678}};
    rd_pat = {8{64'h0F0F_CAFE_BEEF_0001}};

    // ---- reset state ----
    do_reset();
    @(negedge clk);
    chk("reset_outputs", out_bundle(), 64'h0);

    // ---- basic read from port 0, one vector per cycle ----
    req_addr[0] = 32'h1000; req_len[0] = 24'd3;
    tv[0] = '{4'b0001, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,    4'b0000};
    tv[1] = '{4'b0001, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 32'h1000, 4'b0000};
    tv[2] = '{4'b0001, 1'b1, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b1, 32'h1008, 4'b0001};
    tv[3] = '{4'b0001, 1'b1, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b1, 32'h1010, 4'b0001};
    tv[4] = '{4'b0001, 1'b1, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b0, 32'h0,    4'b0001};
    tv[5] = '{4'b0001, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 32'h0,    4'b0000};
    tv[6] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0, 32'h0,    4'b0000};
    tv[7] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,    4'b0000};
    for (int i = 0; i < 8; i++) begin
      tick();
      req = tv[i].req; app_rdy = tv[i].rdy; man_rdv = tv[i].rdv;
      @(negedge clk);
      got = {21'h0, o_gnt, o_done, o_busy, o_app_en, (o_app_en ? o_app_addr : 32'h0), o_rd_valid};
      exp = {21'h0, tv[i].gnt, tv[i].done, tv[i].busy, tv[i].en, tv[i].addr, tv[i].rdval};
      chk($sformatf("read_vec%0d", i), got, exp);
    end
    chk("rd_data_pass", o_rd_data[63:0], rd_pat[63:0]);

    // ---- round-robin with all four requesting, req0 held ----
    do_reset();
    auto_rd = 1'b1; app_rdy = 1'b1; wr_valid = 1'b1; app_wdf_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_len[i] = 24'd1; req_addr[i] = 32'h100 * (i + 1);
      grants[i + (i == 3 ? 1 : 0)] = '0;
    end
    grants[3] = '0;
    req = 4'hF; prev = '0; ng = 0; gap = 0; min_gap = 99;
    for (int c = 0; c < 80 && ng < 5; c++) begin
      tick();
      @(negedge clk);
      if (o_gnt != 0 && prev == 0) begin
        grants[ng] = o_gnt;
        if (ng > 0 && gap < min_gap) min_gap = gap;
        ng++; gap = 0;
      end
      if (o_gnt == 0) gap++;
      if (|o_done) req = req & ~(o_done & 4'b1110);
      prev = o_gnt;
    end
    req = '0;
    chk("rr_count", 64'(ng), 64'd5);
    chk("rr_g0", 64'(grants[0]), 64'h1);
    chk("rr_g1", 64'(grants[1]), 64'h2);
    chk("rr_g2", 64'(grants[2]), 64'h4);
    chk("rr_g3", 64'(grants[3]), 64'h8);
    chk("rr_g4", 64'(grants[4]), 64'h1);
    chk("rr_min_gap", 64'(min_gap), 64'd2);
    repeat (6) tick();
    @(negedge clk);
    chk("no_stray_yet", 64'(o_err_stray), 64'h0);

    // ---- write owner 3, write FIFO not ready for 5 cycles ----
    auto_rd = 1'b0; man_rdv = 1'b0;
    req_addr[3] = 32'h2000; req_len[3] = 24'd2;
    app_rdy = 1'b1; wr_valid = 1'b1; app_wdf_rdy = 1'b0;
    tick(); req = 4'b1000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (o_gnt[3]) break;
      tick();
    end
    chk("wr_gnt", 64'(o_gnt), 64'h8);
    any_rdy = 1'b0; early = 1'b0; bad_cmd = 1'b0; cmds = 0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin tick(); @(negedge clk); end
      any_rdy |= o_wr_ready | o_app_wdf_wren;
      early   |= o_done[3];
      if (o_app_en && app_rdy) begin cmds++; bad_cmd |= (o_app_cmd != 3'b000); end
    end
    tick(); app_wdf_rdy = 1'b1;
    beats = 0; got_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_app_wdf_wren) beats++;
      if (o_app_en && app_rdy) begin cmds++; bad_cmd |= (o_app_cmd != 3'b000); end
      if (o_done[3]) begin got_done = 1'b1; break; end
      tick();
    end
    req = '0;
    chk("wr_ready_blocked", 64'(any_rdy), 64'h0);
    chk("wr_no_early_done", 64'(early), 64'h0);
    chk("wr_done_seen", 64'(got_done), 64'h1);
    chk("wr_beats", 64'(beats), 64'd2);
    chk("wr_cmds", 64'(cmds), 64'd2);
    chk("wr_cmd_code", 64'(bad_cmd), 64'h0);
    chk("wdf_data_pass", o_app_wdf_data[63:0], wr_pat[63:0]);

    // ---- app_rdy toggling, len 4 ----
    repeat (3) tick();
    auto_rd = 1'b1; app_rdy = 1'b0;
    req_addr[0] = 32'h4000; req_len[0] = 24'd4; req = 4'b0001; na = 0;
    for (int c = 0; c < 60; c++) begin
      tick(); app_rdy = ~app_rdy;
      @(negedge clk);
      if (o_app_en && app_rdy) begin
        if (na < 8) addrs[na] = o_app_addr;
        na++;
      end
      if (o_done[0]) break;
    end
    req = '0;
    chk("tog_cmds", 64'(na), 64'd4);
    chk("tog_a0", 64'(addrs[0]), 64'h4000);
    chk("tog_a1", 64'(addrs[1]), 64'h4008);
    chk("tog_a2", 64'(addrs[2]), 64'h4010);
    chk("tog_a3", 64'(addrs[3]), 64'h4018);

    // ---- len 0 on port 2 ----
    repeat (3) tick();
    app_rdy = 1'b1; req_len[2] = 24'd0; req_addr[2] = 32'h3000; req = 4'b0100;
    en_seen = 1'b0; g_at = -1; d_at = -1;
    for (int c = 0; c < 20; c++) begin
      tick();
      @(negedge clk);
      en_seen |= o_app_en;
      if (o_gnt[2] && g_at < 0) g_at = c;
      if (o_done[2]) begin d_at = c; break; end
    end
    req = '0;
    chk("len0_no_cmd", 64'(en_seen), 64'h0);
    chk("len0_done_seen", 64'(d_at >= 0), 64'h1);
    chk("len0_done_lat", 64'(d_at - g_at), 64'd1);

    // ---- address wrap ----
    repeat (3) tick();
    req_addr[1] = 32'hFFFF_FFF8; req_len[1] = 24'd2; req = 4'b0010; na = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      @(negedge clk);
      if (o_app_en && app_rdy) begin
        if (na < 8) addrs[na] = o_app_addr;
        na++;
      end
      if (o_done[1]) break;
    end
    req = '0;
    chk("wrap_cmds", 64'(na), 64'd2);
    chk("wrap_a0", 64'(addrs[0]), 64'hFFFF_FFF8);
    chk("wrap_a1", 64'(addrs[1]), 64'h0);

    // ---- reset mid-read, then stray read data ----
    repeat (3) tick();
    auto_rd = 1'b0; man_rdv = 1'b0; app_rdy = 1'b1;
    req_addr[0] = 32'h5000; req_len[0] = 24'd4; req = 4'b0001; na = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      @(negedge clk);
      if (o_app_en && app_rdy) na++;
      if (na == 2) break;
    end
    chk("rst_two_cmds", 64'(na), 64'd2);
    tick(); rst_n = 1'b0; req = '0;
    @(negedge clk);
    done_rst = |o_done;
    tick();
    @(negedge clk);
    done_rst |= |o_done;
    chk("rst_outputs", out_bundle(), 64'h0);
    tick(); rst_n = 1'b1; man_rdv = 1'b1;
    @(negedge clk);
    chk("stray_not_steered", 64'(o_rd_valid), 64'h0);
    tick(); man_rdv = 1'b0;
    @(negedge clk);
    done_rst |= |o_done;
    chk("stray_flag", 64'(o_err_stray), 64'h1);
    repeat (3) tick();
    @(negedge clk);
    chk("stray_sticky", 64'(o_err_stray), 64'h1);
    chk("rst_no_done", 64'(done_rst), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
